// File: rtl/rmst_fm_tile_ctrl_if.sv
// Tile-load request, feature-map configuration and burst handshake bundle
// between a tile scheduler (master) and rmst_fm_tile_ctrl (slave).
interface rmst_fm_tile_ctrl_if #(
   parameter int AW = 12,
   parameter int CW = 16,
   parameter int DW = 32
) ();
   logic          load_start;
   logic          load_abort;
   logic [DW-1:0] cfg_base_addr;
   logic [CW-1:0] cfg_N;
   logic [CW-1:0] cfg_R;
   logic [CW-1:0] cfg_C;
   logic [CW-1:0] cfg_tn;
   logic [CW-1:0] cfg_tr;
   logic [CW-1:0] cfg_tc;
   logic [CW-1:0] cfg_offset;
   logic [CW-1:0] tile_base_n;
   logic [CW-1:0] tile_base_row;
   logic [CW-1:0] tile_base_col;
   logic          load_fifo_almost_full;
   logic          load_trans_done;
   logic          load_trans_start;
   logic [DW-1:0] param_raddr;
   logic [AW-1:0] param_iolen;
   logic          load_done;
   logic          load_busy;

   modport master (
      output load_start, load_abort, cfg_base_addr, cfg_N, cfg_R, cfg_C,
             cfg_tn, cfg_tr, cfg_tc, cfg_offset, tile_base_n, tile_base_row,
             tile_base_col, load_fifo_almost_full, load_trans_done,
      input  load_trans_start, param_raddr, param_iolen, load_done, load_busy
   );

   modport slave (
      input  load_start, load_abort, cfg_base_addr, cfg_N, cfg_R, cfg_C,
             cfg_tn, cfg_tr, cfg_tc, cfg_offset, tile_base_n, tile_base_row,
             tile_base_col, load_fifo_almost_full, load_trans_done,
      output load_trans_start, param_raddr, param_iolen, load_done, load_busy
   );
endinterface

// File: rtl/rmst_fm_tile_ctrl.sv
// Walks an edge-clipped feature-map tile channel by channel, row by row, and
// issues one burst request per MAX_BURST-word row segment.
module rmst_fm_tile_ctrl #(
   parameter int AW        = 12,
   parameter int CW        = 16,
   parameter int DW        = 32,
   parameter int MAX_BURST = 64
) (
   input logic                clk,
   input logic                rst_n,
   rmst_fm_tile_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, CONFIG, WAIT, TRANS, DONE} state_t;
   state_t state, next_state;

   logic [DW-1:0] base;
   logic [CW-1:0] map_r, map_c, org_n, org_r, org_c;
   logic [CW-1:0] en, er, ec;
   logic [CW-1:0] n_cnt, r_cnt, col_off;
   logic          last, abort_pend;
   logic          trans_start, done_pulse;
   logic [DW-1:0] raddr;
   logic [AW-1:0] iolen;

   logic [CW-1:0] en_in, er_in, ec_in, remaining;
   logic          empty_in, seg_last, row_last, tile_last;
   logic [DW-1:0] word_addr;

   function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return (a > b) ? a - b : '0;
   endfunction

   function automatic logic [CW-1:0] clip_min(input logic [CW:0] a, input logic [CW-1:0] b);
      return (a < {1'b0, b}) ? a[CW-1:0] : b;
   endfunction

   // Tile extents are clipped from the live inputs and captured on acceptance.
   always_comb begin
      en_in    = clip_min({1'b0, bus.cfg_tn}, sat_sub(bus.cfg_N, bus.tile_base_n));
      er_in    = clip_min({1'b0, bus.cfg_tr}, sat_sub(bus.cfg_R, bus.tile_base_row));
      ec_in    = clip_min({1'b0, bus.cfg_tc} + {1'b0, bus.cfg_offset},
                          sat_sub(bus.cfg_C, bus.tile_base_col));
      empty_in = (en_in == '0) || (er_in == '0) || (ec_in == '0);
   end

   always_comb begin
      remaining = ec - col_off;
      seg_last  = remaining <= CW'(MAX_BURST);
      row_last  = seg_last && (r_cnt == er - CW'(1));
      tile_last = row_last && (n_cnt == en - CW'(1));
      word_addr = base
                + (DW'(org_n) + DW'(n_cnt)) * DW'(map_r) * DW'(map_c)
                + (DW'(org_r) + DW'(r_cnt)) * DW'(map_c)
                + DW'(org_c) + DW'(col_off);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Abort wins everywhere; inside TRANS it only takes effect once the burst drains.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.load_start) begin
               if (empty_in)                       next_state = DONE;
               else if (bus.load_fifo_almost_full) next_state = WAIT;
               else                                next_state = CONFIG;
            end
         end
         WAIT: begin
            if (bus.load_abort)                  next_state = IDLE;
            else if (!bus.load_fifo_almost_full) next_state = CONFIG;
         end
         CONFIG: next_state = bus.load_abort ? IDLE : TRANS;
         TRANS: begin
            if (bus.load_trans_done)
               next_state = (bus.load_abort || abort_pend) ? IDLE : DONE;
         end
         DONE: begin
            if (bus.load_abort || last)         next_state = IDLE;
            else if (bus.load_fifo_almost_full) next_state = WAIT;
            else                                next_state = CONFIG;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base        <= '0;
         map_r       <= '0;
         map_c       <= '0;
         org_n       <= '0;
         org_r       <= '0;
         org_c       <= '0;
         en          <= '0;
         er          <= '0;
         ec          <= '0;
         n_cnt       <= '0;
         r_cnt       <= '0;
         col_off     <= '0;
         last        <= 1'b0;
         abort_pend  <= 1'b0;
         trans_start <= 1'b0;
         done_pulse  <= 1'b0;
         raddr       <= '0;
         iolen       <= '0;
      end else begin
         trans_start <= 1'b0;
         done_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load_start) begin
                  base       <= bus.cfg_base_addr;
                  map_r      <= bus.cfg_R;
                  map_c      <= bus.cfg_C;
                  org_n      <= bus.tile_base_n;
                  org_r      <= bus.tile_base_row;
                  org_c      <= bus.tile_base_col;
                  en         <= en_in;
                  er         <= er_in;
                  ec         <= ec_in;
                  last       <= empty_in;
                  abort_pend <= 1'b0;
                  n_cnt      <= '0;
                  r_cnt      <= '0;
                  col_off    <= '0;
               end
            end
            CONFIG: begin
               if (!bus.load_abort) begin
                  raddr       <= word_addr << 2;
                  iolen       <= seg_last ? AW'(remaining) : AW'(MAX_BURST);
                  trans_start <= 1'b1;
                  last        <= tile_last;
                  if (!seg_last) begin
                     col_off <= col_off + CW'(MAX_BURST);
                  end else begin
                     col_off <= '0;
                     r_cnt   <= row_last ? '0 : r_cnt + CW'(1);
                     if (row_last) n_cnt <= tile_last ? '0 : n_cnt + CW'(1);
                  end
               end
            end
            TRANS: if (bus.load_abort) abort_pend <= 1'b1;
            DONE:  if (!bus.load_abort && last) done_pulse <= 1'b1;
            default: ;
         endcase
         if (bus.load_abort && state != IDLE) begin
            n_cnt   <= '0;
            r_cnt   <= '0;
            col_off <= '0;
         end
      end
   end

   assign bus.load_trans_start = trans_start;
   assign bus.param_raddr      = raddr;
   assign bus.param_iolen      = iolen;
   assign bus.load_done        = done_pulse;
   assign bus.load_busy        = (state != IDLE);

endmodule

// File: tb/tb_rmst_fm_tile_ctrl.sv
// Bench for rmst_fm_tile_ctrl: directed scenarios plus random tiles checked
// against a loop-nest model of the tile walk.
module tb_rmst_fm_tile_ctrl;
   localparam int AW = 12;
   localparam int CW = 16;
   localparam int DW = 32;
   localparam int MB = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rmst_fm_tile_ctrl_if #(.AW(AW), .CW(CW), .DW(DW)) bus ();
   rmst_fm_tile_ctrl #(.AW(AW), .CW(CW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      longint base, N, R, C, tn, tr, tc, off, bn, br, bc;
   } tcfg_t;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] exp_addr[$];
   int          exp_len[$];
   logic [31:0] obs_addr[$];
   int          obs_len[$];
   int          obs_cyc[$];
   int done_cnt, done_cyc, idle_cyc;

   function automatic longint clip(longint nominal, longint lim, longint org);
      longint d;
      d = lim - org;
      if (d < 0) d = 0;
      return (nominal < d) ? nominal : d;
   endfunction

   // Expected burst list: channel outer, row inner, MAX_BURST-word segments.
   function automatic void model(tcfg_t c);
      longint en, er, ec, wa;
      exp_addr.delete();
      exp_len.delete();
      en = clip(c.tn, c.N, c.bn);
      er = clip(c.tr, c.R, c.br);
      ec = clip(c.tc + c.off, c.C, c.bc);
      for (longint n = 0; n < en; n++)
         for (longint r = 0; r < er; r++)
            for (longint w = 0; w < ec; w += MB) begin
               wa = (c.base + (c.bn + n) * c.R * c.C + (c.br + r) * c.C + c.bc + w) & 64'hFFFF_FFFF;
               exp_addr.push_back(32'((wa * 4) & 64'hFFFF_FFFF));
               exp_len.push_back(int'(((ec - w) < MB) ? (ec - w) : MB));
            end
   endfunction

   function automatic tcfg_t nominal_cfg();
      tcfg_t c;
      c.base = 0; c.N = 4; c.R = 32; c.C = 32; c.tn = 2; c.tr = 2; c.tc = 16;
      c.off = 2; c.bn = 0; c.br = 0; c.bc = 0;
      return c;
   endfunction

   task automatic apply_cfg(input tcfg_t c);
      bus.cfg_base_addr = DW'(c.base);
      bus.cfg_N = CW'(c.N);   bus.cfg_R = CW'(c.R);   bus.cfg_C = CW'(c.C);
      bus.cfg_tn = CW'(c.tn); bus.cfg_tr = CW'(c.tr); bus.cfg_tc = CW'(c.tc);
      bus.cfg_offset = CW'(c.off);
      bus.tile_base_n = CW'(c.bn); bus.tile_base_row = CW'(c.br); bus.tile_base_col = CW'(c.bc);
   endtask

   // Cycle 0 is the load_start cycle. af_mode 1: almost_full high in cycles 0..9;
   // af_mode 2: almost_full high for 6 cycles from the first load_trans_done.
   task automatic run_tile(input tcfg_t c, input int af_mode, input int abort_k, input int budget);
      int cyc, abort_at, af_until, tail;
      int done_at[$];
      bit af_used;
      obs_addr.delete(); obs_len.delete(); obs_cyc.delete();
      done_cnt = 0; done_cyc = -1; idle_cyc = -1;
      abort_at = -1; af_until = -1; tail = -1; af_used = 1'b0;
      apply_cfg(c);
      @(posedge clk); #1;
      bus.load_start = 1'b1;
      bus.load_fifo_almost_full = (af_mode == 1);
      cyc = 0;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         bus.load_start = 1'b0;
         bus.load_trans_done = 1'b0;
         bus.load_abort = 1'b0;
         apply_cfg('{default: 0});
         if (bus.load_trans_start) begin
            obs_addr.push_back(bus.param_raddr);
            obs_len.push_back(int'(bus.param_iolen));
            obs_cyc.push_back(cyc);
            if (obs_addr.size() - 1 == abort_k) abort_at = cyc + 1;
            done_at.push_back(cyc + 3);
         end
         if (bus.load_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!bus.load_busy && idle_cyc < 0) idle_cyc = cyc;
         if (done_at.size() > 0 && done_at[0] == cyc) begin
            void'(done_at.pop_front());
            bus.load_trans_done = 1'b1;
            if (af_mode == 2 && !af_used) begin
               af_until = cyc + 5;
               af_used = 1'b1;
            end
         end
         if (cyc == abort_at) bus.load_abort = 1'b1;
         bus.load_fifo_almost_full = (af_mode == 1 && cyc < 10) || (cyc <= af_until);
         if (idle_cyc >= 0 && tail < 0) tail = cyc + 8;
         if (cyc == tail || cyc >= budget) break;
      end
      bus.load_fifo_almost_full = 1'b0;
      bus.load_trans_done = 1'b0;
      bus.load_abort = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({bus.load_trans_start, bus.load_done, bus.load_busy} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b required 000", {bus.load_trans_start, bus.load_done, bus.load_busy});
      end
      n_checks++;
      if (bus.param_raddr !== 32'h0 || bus.param_iolen !== 12'h0) begin
         n_fail++; $display("FAIL reset_params: got raddr=%0h iolen=%0h required 0/0", bus.param_raddr, bus.param_iolen);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      bus.load_trans_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.load_trans_done = 1'b0;
         n_checks++;
         if ({bus.load_trans_start, bus.load_done, bus.load_busy} !== 3'b000) begin
            n_fail++; $display("FAIL idle_ignore_done%0d: got %b required 000", i, {bus.load_trans_start, bus.load_done, bus.load_busy});
         end
      end
   endtask

   task automatic test_nominal();
      logic [31:0] want[4] = '{32'h0, 32'h80, 32'h1000, 32'h1080};
      logic [31:0] a;
      int l, t;
      run_tile(nominal_cfg(), 0, -1, 200);
      n_checks++;
      if (obs_addr.size() !== 4) begin
         n_fail++; $display("FAIL nominal_count: got %0d required 4", obs_addr.size());
      end
      for (int i = 0; i < 4; i++) begin
         a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
         l = (i < obs_len.size()) ? obs_len[i] : -1;
         t = (i < obs_cyc.size()) ? obs_cyc[i] : -1;
         n_checks++;
         if (a !== want[i] || l !== 18 || t !== 2 + 6 * i) begin
            n_fail++; $display("FAIL nominal_burst%0d: got addr=%0h len=%0d cyc=%0d required addr=%0h len=18 cyc=%0d", i, a, l, t, want[i], 2 + 6 * i);
         end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== 25 || idle_cyc !== 25) begin
         n_fail++; $display("FAIL nominal_done: got cnt=%0d cyc=%0d idle=%0d required 1/25/25", done_cnt, done_cyc, idle_cyc);
      end
   endtask

   task automatic test_burst_split();
      tcfg_t c = nominal_cfg();
      logic [31:0] want_a[3] = '{32'h0, 32'h100, 32'h200};
      int want_l[3] = '{64, 64, 22};
      logic [31:0] a;
      int l;
      c.N = 1; c.R = 1; c.C = 200; c.tn = 1; c.tr = 1; c.tc = 150; c.off = 0;
      run_tile(c, 0, -1, 200);
      n_checks++;
      if (obs_addr.size() !== 3 || done_cnt !== 1) begin
         n_fail++; $display("FAIL split_count: got bursts=%0d done=%0d required 3/1", obs_addr.size(), done_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
         l = (i < obs_len.size()) ? obs_len[i] : -1;
         n_checks++;
         if (a !== want_a[i] || l !== want_l[i]) begin
            n_fail++; $display("FAIL split_burst%0d: got addr=%0h len=%0d required addr=%0h len=%0d", i, a, l, want_a[i], want_l[i]);
         end
      end
   endtask

   task automatic test_edge_clip();
      tcfg_t c = nominal_cfg();
      logic [31:0] a;
      int l;
      c.tr = 8; c.br = 28; c.off = 0; c.bc = 3;
      model(c);
      run_tile(c, 0, -1, 300);
      n_checks++;
      if (obs_addr.size() !== 8 || done_cnt !== 1) begin
         n_fail++; $display("FAIL clip_rows: got bursts=%0d done=%0d required 8/1", obs_addr.size(), done_cnt);
      end
      for (int i = 0; i < exp_addr.size(); i++) begin
         a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
         l = (i < obs_len.size()) ? obs_len[i] : -1;
         n_checks++;
         if (a !== exp_addr[i] || l !== exp_len[i]) begin
            n_fail++; $display("FAIL clip_burst%0d: got addr=%0h len=%0d required addr=%0h len=%0d", i, a, l, exp_addr[i], exp_len[i]);
         end
      end
   endtask

   task automatic test_empty();
      tcfg_t c = nominal_cfg();
      c.bn = c.N;
      run_tile(c, 0, -1, 100);
      n_checks++;
      if (obs_addr.size() !== 0) begin
         n_fail++; $display("FAIL empty_no_start: got %0d bursts required 0", obs_addr.size());
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== 2) begin
         n_fail++; $display("FAIL empty_done: got cnt=%0d cyc=%0d required 1/2", done_cnt, done_cyc);
      end
   endtask

   task automatic test_backpressure();
      tcfg_t c = nominal_cfg();
      int t0, t1;
      model(c);
      run_tile(c, 1, -1, 300);
      t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
      n_checks++;
      if (t0 !== 12) begin
         n_fail++; $display("FAIL bp_wait_first_start: got cyc=%0d required 12", t0);
      end
      n_checks++;
      if (obs_addr.size() !== exp_addr.size() || done_cnt !== 1) begin
         n_fail++; $display("FAIL bp_wait_tile: got bursts=%0d done=%0d required %0d/1", obs_addr.size(), done_cnt, exp_addr.size());
      end
      run_tile(c, 2, -1, 300);
      t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
      t1 = (obs_cyc.size() > 1) ? obs_cyc[1] : -1;
      n_checks++;
      if (t1 - t0 !== 11) begin
         n_fail++; $display("FAIL bp_done_rewait: got gap=%0d required 11", t1 - t0);
      end
      n_checks++;
      if (obs_addr.size() !== 4 || done_cnt !== 1) begin
         n_fail++; $display("FAIL bp_done_tile: got bursts=%0d done=%0d required 4/1", obs_addr.size(), done_cnt);
      end
   endtask

   task automatic test_abort();
      tcfg_t c = nominal_cfg();
      logic [31:0] a;
      int l;
      run_tile(c, 0, 1, 200);
      n_checks++;
      if (obs_addr.size() !== 2 || done_cnt !== 0) begin
         n_fail++; $display("FAIL abort_stop: got bursts=%0d done=%0d required 2/0", obs_addr.size(), done_cnt);
      end
      n_checks++;
      if (idle_cyc !== 12) begin
         n_fail++; $display("FAIL abort_idle: got idle cyc=%0d required 12", idle_cyc);
      end
      model(c);
      run_tile(c, 0, -1, 200);
      n_checks++;
      if (obs_addr.size() !== exp_addr.size() || done_cnt !== 1) begin
         n_fail++; $display("FAIL abort_restart_count: got bursts=%0d done=%0d required %0d/1", obs_addr.size(), done_cnt, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size(); i++) begin
         a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
         l = (i < obs_len.size()) ? obs_len[i] : -1;
         n_checks++;
         if (a !== exp_addr[i] || l !== exp_len[i]) begin
            n_fail++; $display("FAIL abort_restart%0d: got addr=%0h len=%0d required addr=%0h len=%0d", i, a, l, exp_addr[i], exp_len[i]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      tcfg_t c = nominal_cfg();
      logic [31:0] a;
      int l;
      bit seen;
      c.base = 32'h40;
      apply_cfg(c);
      @(posedge clk); #1;
      bus.load_start = 1'b1;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk); #1;
         seen = bus.load_trans_start;
      end
      n_checks++;
      if (seen !== 1'b1 || bus.param_raddr !== 32'h100) begin
         n_fail++; $display("FAIL rst_pre_burst: got start=%0b raddr=%0h required 1/100", seen, bus.param_raddr);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.load_trans_start, bus.load_done, bus.load_busy} !== 3'b000 ||
          bus.param_raddr !== 32'h0 || bus.param_iolen !== 12'h0) begin
         n_fail++; $display("FAIL rst_async_clear: got flags=%b raddr=%0h iolen=%0h required 000/0/0",
                            {bus.load_trans_start, bus.load_done, bus.load_busy}, bus.param_raddr, bus.param_iolen);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i == 0) bus.load_trans_done = 1'b1;
         else        bus.load_trans_done = 1'b0;
         n_checks++;
         if ({bus.load_trans_start, bus.load_done, bus.load_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_quiet%0d: got %b required 000", i, {bus.load_trans_start, bus.load_done, bus.load_busy});
         end
      end
      bus.load_trans_done = 1'b0;
      model(c);
      run_tile(c, 0, -1, 200);
      n_checks++;
      if (obs_addr.size() !== exp_addr.size() || done_cnt !== 1) begin
         n_fail++; $display("FAIL rst_next_count: got bursts=%0d done=%0d required %0d/1", obs_addr.size(), done_cnt, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size(); i++) begin
         a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
         l = (i < obs_len.size()) ? obs_len[i] : -1;
         n_checks++;
         if (a !== exp_addr[i] || l !== exp_len[i]) begin
            n_fail++; $display("FAIL rst_next%0d: got addr=%0h len=%0d required addr=%0h len=%0d", i, a, l, exp_addr[i], exp_len[i]);
         end
      end
   endtask

   task automatic test_random();
      tcfg_t c;
      logic [31:0] a;
      int l;
      for (int t = 0; t < 8; t++) begin
         c.base = longint'($urandom);
         c.N = $urandom_range(1, 6);   c.R = $urandom_range(1, 12); c.C = $urandom_range(1, 200);
         c.tn = $urandom_range(1, 4);  c.tr = $urandom_range(1, 4); c.tc = $urandom_range(1, 150);
         c.off = $urandom_range(0, 4);
         c.bn = $urandom_range(0, int'(c.N)); c.br = $urandom_range(0, int'(c.R));
         c.bc = $urandom_range(0, int'(c.C));
         model(c);
         run_tile(c, 0, -1, 2000);
         n_checks++;
         if (obs_addr.size() !== exp_addr.size() || done_cnt !== 1) begin
            n_fail++; $display("FAIL rand%0d_count: got bursts=%0d done=%0d required %0d/1", t, obs_addr.size(), done_cnt, exp_addr.size());
         end
         for (int i = 0; i < exp_addr.size(); i++) begin
            a = (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
            l = (i < obs_len.size()) ? obs_len[i] : -1;
            n_checks++;
            if (a !== exp_addr[i] || l !== exp_len[i]) begin
               n_fail++; $display("FAIL rand%0d_burst%0d: got addr=%0h len=%0d required addr=%0h len=%0d", t, i, a, l, exp_addr[i], exp_len[i]);
            end
         end
      end
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.load_abort = 1'b0;
      bus.load_fifo_almost_full = 1'b0;
      bus.load_trans_done = 1'b0;
      apply_cfg('{default: 0});
      test_reset();
      test_nominal();
      test_burst_split();
      test_edge_clip();
      test_empty();
      test_backpressure();
      test_abort();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
